// File: rtl/mem_stage_if.sv
// Bundle of the upstream instruction, data-memory and writeback signals of mem_stage.
// slave is the stage itself; master is whatever drives it (pipeline, memory model, bench).
interface mem_stage_if #(
    parameter int DBITS      = 32,
    parameter int REGNO_BITS = 4
);
    logic                  inValid;
    logic [DBITS-1:0]      inAlu;
    logic [DBITS-1:0]      inStData;
    logic                  isLoad;
    logic                  isStore;
    logic                  regWrEn;
    logic [REGNO_BITS-1:0] destReg;
    logic                  stall;
    logic                  memReq;
    logic                  memWe;
    logic [DBITS-1:0]      memAddr;
    logic [DBITS-1:0]      memWData;
    logic [DBITS-1:0]      memRData;
    logic                  memAck;
    logic                  wbValid;
    logic                  wbWrEn;
    logic [REGNO_BITS-1:0] wbReg;
    logic [DBITS-1:0]      wbData;
    logic                  memErr;

    // Handshake: memReq rises and then holds memWe/memAddr/memWData stable until the
    // edge where memAck=1 is sampled (completion) or the wait budget runs out (abort).
    // wbValid and memErr are single-cycle pulses; stall=1 means upstream must hold.
    modport slave (
        input  inValid, inAlu, inStData, isLoad, isStore, regWrEn, destReg,
        input  memRData, memAck,
        output stall, memReq, memWe, memAddr, memWData,
        output wbValid, wbWrEn, wbReg, wbData, memErr
    );

    modport master (
        output inValid, inAlu, inStData, isLoad, isStore, regWrEn, destReg,
        output memRData, memAck,
        input  stall, memReq, memWe, memAddr, memWData,
        input  wbValid, wbWrEn, wbReg, wbData, memErr
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores over req/ack, stalls upstream while
// waiting, aborts after MAX_WAIT cycles. Define MEM_STAGE_ALIGN_CHECK_EN to fault misaligned accesses.
module mem_stage #(
    parameter int DBITS      = 32,
    parameter int REGNO_BITS = 4,
    parameter int MAX_WAIT   = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    mem_stage_if.slave  bus,
    output logic        dbg_state_o
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t                state_q;
    logic [7:0]            cnt_q;
    logic [7:0]            cnt_d;
    logic                  stall_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [DBITS-1:0]      mem_addr_q;
    logic [DBITS-1:0]      mem_wdata_q;
    logic                  ld_wr_en_q;
    logic                  wb_valid_q;
    logic                  wb_wr_en_q;
    logic [REGNO_BITS-1:0] wb_reg_q;
    logic [REGNO_BITS-1:0] dest_q;
    logic [DBITS-1:0]      wb_data_q;
    logic                  mem_err_q;

    logic                  mem_op;
    logic                  is_store_op;
    logic                  misaligned;
    logic [DBITS-1:0]      issue_addr;
    logic                  timeout;

    assign mem_op      = bus.isLoad | bus.isStore;
    // Both flags high is treated as a load.
    assign is_store_op = bus.isStore & ~bus.isLoad;
    assign cnt_d       = cnt_q + 8'd1;
    assign timeout     = (cnt_q == 8'(MAX_WAIT - 1));

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign misaligned = (bus.inAlu[1:0] != 2'b00);
    assign issue_addr = bus.inAlu;
`else
    assign misaligned = 1'b0;
    assign issue_addr = {bus.inAlu[DBITS-1:2], 2'b00};
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            stall_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ld_wr_en_q  <= 1'b0;
            dest_q      <= '0;
            wb_valid_q  <= 1'b0;
            wb_wr_en_q  <= 1'b0;
            wb_reg_q    <= '0;
            wb_data_q   <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            wb_wr_en_q <= 1'b0;
            mem_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.inValid) begin
                        if (!mem_op) begin
                            wb_valid_q <= 1'b1;
                            wb_wr_en_q <= bus.regWrEn;
                            wb_reg_q   <= bus.destReg;
                            wb_data_q  <= bus.inAlu;
                        end else if (misaligned) begin
                            wb_valid_q <= 1'b1;
                            mem_err_q  <= 1'b1;
                            wb_reg_q   <= bus.destReg;
                            wb_data_q  <= bus.inAlu;
                        end else begin
                            state_q     <= WAIT;
                            stall_q     <= 1'b1;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= is_store_op;
                            mem_addr_q  <= issue_addr;
                            mem_wdata_q <= bus.inStData;
                            ld_wr_en_q  <= bus.regWrEn;
                            dest_q      <= bus.destReg;
                            cnt_q       <= '0;
                        end
                    end
                end
                WAIT: begin
                    // Ack takes priority over a timeout on the same edge.
                    if (bus.memAck) begin
                        state_q    <= IDLE;
                        stall_q    <= 1'b0;
                        mem_req_q  <= 1'b0;
                        wb_valid_q <= 1'b1;
                        wb_wr_en_q <= mem_we_q ? 1'b0 : ld_wr_en_q;
                        wb_reg_q   <= dest_q;
                        wb_data_q  <= mem_we_q ? mem_addr_q : bus.memRData;
                    end else if (timeout) begin
                        state_q    <= IDLE;
                        stall_q    <= 1'b0;
                        mem_req_q  <= 1'b0;
                        wb_valid_q <= 1'b1;
                        mem_err_q  <= 1'b1;
                        wb_reg_q   <= dest_q;
                        wb_data_q  <= mem_addr_q;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.stall    = stall_q;
    assign bus.memReq   = mem_req_q;
    assign bus.memWe    = mem_we_q;
    assign bus.memAddr  = mem_addr_q;
    assign bus.memWData = mem_wdata_q;
    assign bus.wbValid  = wb_valid_q;
    assign bus.wbWrEn   = wb_wr_en_q;
    assign bus.wbReg    = wb_reg_q;
    assign bus.wbData   = wb_data_q;
    assign bus.memErr   = mem_err_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (MAX_WAIT=4): reset, ALU ops, load, store, timeout,
// misaligned address and reset in the middle of an access.
module tb_mem_stage;

    logic clk;
    logic reset_n;
    logic dbg_state;
    int   errors;
    int   checks;

    mem_stage_if #(.DBITS(32), .REGNO_BITS(4)) bus ();

    mem_stage #(.DBITS(32), .REGNO_BITS(4), .MAX_WAIT(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.inValid  = 1'b0;
        bus.inAlu    = '0;
        bus.inStData = '0;
        bus.isLoad   = 1'b0;
        bus.isStore  = 1'b0;
        bus.regWrEn  = 1'b0;
        bus.destReg  = '0;
        bus.memRData = '0;
        bus.memAck   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n      = 1'b0;
        bus.inValid  = 1'b1;
        bus.isLoad   = 1'b1;
        bus.inAlu    = 32'h100;
        bus.regWrEn  = 1'b1;
        bus.destReg  = 4'd9;
        tick();
        tick();
        checks++;
        if ({bus.memReq, bus.memWe, bus.wbValid, bus.wbWrEn, bus.memErr, bus.stall} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got req=%b we=%b wbv=%b wbwe=%b err=%b stall=%b exp all 0",
                     bus.memReq, bus.memWe, bus.wbValid, bus.wbWrEn, bus.memErr, bus.stall);
        end
        checks++;
        if ({bus.memAddr, bus.memWData, bus.wbData, bus.wbReg} !== 100'b0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h wbdata=%h wbreg=%h exp 0",
                     bus.memAddr, bus.memWData, bus.wbData, bus.wbReg);
        end
        idle_inputs();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        bus.inValid = 1'b1;
        bus.inAlu   = 32'h0000_1234;
        bus.regWrEn = 1'b1;
        bus.destReg = 4'd5;
        tick();
        checks++;
        if ({bus.wbValid, bus.wbWrEn, bus.wbReg, bus.wbData, bus.stall} !== {1'b1, 1'b1, 4'd5, 32'h0000_1234, 1'b0}) begin
            errors++;
            $display("FAIL alu_op: got v=%b we=%b reg=%0d data=%h stall=%b exp v=1 we=1 reg=5 data=00001234 stall=0",
                     bus.wbValid, bus.wbWrEn, bus.wbReg, bus.wbData, bus.stall);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_data [4] = '{32'hA0, 32'hB1, 32'hC2, 32'hD3};
        logic        exp_we   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            bus.inValid = 1'b1;
            bus.inAlu   = exp_data[i];
            bus.regWrEn = exp_we[i];
            bus.destReg = 4'(i + 1);
            tick();
            checks++;
            if ({bus.wbValid, bus.wbWrEn, bus.wbReg, bus.wbData} !== {1'b1, exp_we[i], 4'(i + 1), exp_data[i]}) begin
                errors++;
                $display("FAIL b2b_%0d: got v=%b we=%b reg=%0d data=%h exp v=1 we=%b reg=%0d data=%h",
                         i, bus.wbValid, bus.wbWrEn, bus.wbReg, bus.wbData, exp_we[i], i + 1, exp_data[i]);
            end
        end
        idle_inputs();
        tick();
        checks++;
        if (bus.wbValid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got wbValid=%b exp 0", bus.wbValid);
        end
    endtask

    task automatic test_load();
        bus.inValid = 1'b1;
        bus.isLoad  = 1'b1;
        bus.inAlu   = 32'h100;
        bus.regWrEn = 1'b1;
        bus.destReg = 4'd3;
        tick();
        // An ALU op presented while waiting must be ignored.
        bus.isLoad = 1'b0;
        bus.inAlu  = 32'h7777;
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if ({bus.memReq, bus.memWe, bus.memAddr, bus.stall, bus.wbValid} !== {1'b1, 1'b0, 32'h100, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL load_wait_c%0d: got req=%b we=%b addr=%h stall=%b wbv=%b exp req=1 we=0 addr=100 stall=1 wbv=0",
                         c, bus.memReq, bus.memWe, bus.memAddr, bus.stall, bus.wbValid);
            end
            if (c == 3) begin
                bus.memAck   = 1'b1;
                bus.memRData = 32'hDEAD_BEEF;
            end
            tick();
        end
        bus.inValid = 1'b0;
        bus.memAck  = 1'b0;
        checks++;
        if ({bus.wbValid, bus.wbWrEn, bus.wbReg, bus.wbData, bus.memReq, bus.stall, bus.memErr}
            !== {1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL load_done: got v=%b we=%b reg=%0d data=%h req=%b stall=%b err=%b exp v=1 we=1 reg=3 data=deadbeef req=0 stall=0 err=0",
                     bus.wbValid, bus.wbWrEn, bus.wbReg, bus.wbData, bus.memReq, bus.stall, bus.memErr);
        end
        tick();
        checks++;
        if (bus.wbValid !== 1'b0) begin
            errors++;
            $display("FAIL load_pulse: got wbValid=%b exp 0", bus.wbValid);
        end
        idle_inputs();
    endtask

    task automatic test_store();
        bus.inValid  = 1'b1;
        bus.isStore  = 1'b1;
        bus.inAlu    = 32'h200;
        bus.inStData = 32'h55;
        bus.regWrEn  = 1'b1;
        bus.destReg  = 4'd7;
        tick();
        idle_inputs();
        checks++;
        if ({bus.memReq, bus.memWe, bus.memAddr, bus.memWData} !== {1'b1, 1'b1, 32'h200, 32'h55}) begin
            errors++;
            $display("FAIL store_req: got req=%b we=%b addr=%h wdata=%h exp req=1 we=1 addr=200 wdata=55",
                     bus.memReq, bus.memWe, bus.memAddr, bus.memWData);
        end
        bus.memAck = 1'b1;
        tick();
        bus.memAck = 1'b0;
        checks++;
        if ({bus.wbValid, bus.wbWrEn, bus.wbData, bus.memReq, bus.memErr} !== {1'b1, 1'b0, 32'h200, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL store_done: got v=%b we=%b data=%h req=%b err=%b exp v=1 we=0 data=200 req=0 err=0",
                     bus.wbValid, bus.wbWrEn, bus.wbData, bus.memReq, bus.memErr);
        end
        tick();
    endtask

    task automatic test_timeout();
        bus.inValid = 1'b1;
        bus.isLoad  = 1'b1;
        bus.inAlu   = 32'h300;
        bus.regWrEn = 1'b1;
        tick();
        idle_inputs();
        for (int c = 1; c <= 4; c++) begin
            checks++;
            if ({bus.memReq, bus.memErr, bus.wbValid} !== 3'b100) begin
                errors++;
                $display("FAIL timeout_wait_c%0d: got req=%b err=%b wbv=%b exp req=1 err=0 wbv=0",
                         c, bus.memReq, bus.memErr, bus.wbValid);
            end
            tick();
        end
        checks++;
        if ({bus.memErr, bus.wbValid, bus.wbWrEn, bus.memReq, bus.stall} !== 5'b11000) begin
            errors++;
            $display("FAIL timeout_abort: got err=%b v=%b we=%b req=%b stall=%b exp err=1 v=1 we=0 req=0 stall=0",
                     bus.memErr, bus.wbValid, bus.wbWrEn, bus.memReq, bus.stall);
        end
        tick();
        checks++;
        if ({bus.memErr, bus.wbValid} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_pulse: got err=%b v=%b exp 0 0", bus.memErr, bus.wbValid);
        end
    endtask

    task automatic test_ack_at_limit();
        bus.inValid = 1'b1;
        bus.isLoad  = 1'b1;
        bus.inAlu   = 32'h304;
        bus.regWrEn = 1'b1;
        bus.destReg = 4'd12;
        tick();
        idle_inputs();
        tick();
        tick();
        tick();
        checks++;
        if (bus.memReq !== 1'b1) begin
            errors++;
            $display("FAIL limit_req: got req=%b exp 1 on 4th cycle", bus.memReq);
        end
        bus.memAck   = 1'b1;
        bus.memRData = 32'hCAFE_F00D;
        tick();
        idle_inputs();
        checks++;
        if ({bus.memErr, bus.wbValid, bus.wbWrEn, bus.wbReg, bus.wbData} !== {1'b0, 1'b1, 1'b1, 4'd12, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL limit_done: got err=%b v=%b we=%b reg=%0d data=%h exp err=0 v=1 we=1 reg=12 data=cafef00d",
                     bus.memErr, bus.wbValid, bus.wbWrEn, bus.wbReg, bus.wbData);
        end
        tick();
    endtask

    task automatic test_misalign();
        bus.inValid = 1'b1;
        bus.isLoad  = 1'b1;
        bus.inAlu   = 32'h102;
        bus.regWrEn = 1'b1;
        bus.destReg = 4'd2;
        tick();
        idle_inputs();
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        checks++;
        if ({bus.memErr, bus.wbValid, bus.wbWrEn, bus.memReq, bus.stall} !== 5'b11000) begin
            errors++;
            $display("FAIL misalign_fault: got err=%b v=%b we=%b req=%b stall=%b exp err=1 v=1 we=0 req=0 stall=0",
                     bus.memErr, bus.wbValid, bus.wbWrEn, bus.memReq, bus.stall);
        end
        tick();
`else
        checks++;
        if ({bus.memReq, bus.memAddr} !== {1'b1, 32'h100}) begin
            errors++;
            $display("FAIL misalign_addr: got req=%b addr=%h exp req=1 addr=100", bus.memReq, bus.memAddr);
        end
        bus.memAck   = 1'b1;
        bus.memRData = 32'h1357_9BDF;
        tick();
        idle_inputs();
        checks++;
        if ({bus.wbValid, bus.memErr, bus.wbData} !== {1'b1, 1'b0, 32'h1357_9BDF}) begin
            errors++;
            $display("FAIL misalign_done: got v=%b err=%b data=%h exp v=1 err=0 data=13579bdf",
                     bus.wbValid, bus.memErr, bus.wbData);
        end
        tick();
`endif
    endtask

    task automatic test_reset_mid();
        bus.inValid  = 1'b1;
        bus.isStore  = 1'b1;
        bus.inAlu    = 32'h400;
        bus.inStData = 32'hABCD;
        tick();
        idle_inputs();
        tick();
        checks++;
        if ({bus.memReq, bus.stall} !== 2'b11) begin
            errors++;
            $display("FAIL rstmid_pre: got req=%b stall=%b exp 1 1", bus.memReq, bus.stall);
        end
        reset_n = 1'b0;
        tick();
        checks++;
        if ({bus.memReq, bus.stall, bus.memWe, bus.memAddr} !== {3'b000, 32'h0}) begin
            errors++;
            $display("FAIL rstmid_clear: got req=%b stall=%b we=%b addr=%h exp all 0",
                     bus.memReq, bus.stall, bus.memWe, bus.memAddr);
        end
        reset_n    = 1'b1;
        bus.memAck = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if ({bus.wbValid, bus.memErr, bus.memReq} !== 3'b000) begin
                errors++;
                $display("FAIL rstmid_late_ack_%0d: got v=%b err=%b req=%b exp 0 0 0",
                         c, bus.wbValid, bus.memErr, bus.memReq);
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        reset_n = 1'b0;
        idle_inputs();
        test_reset();
        test_alu();
        test_back_to_back();
        test_load();
        test_store();
        test_timeout();
        test_ack_at_limit();
        test_misalign();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
